regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  - Shares the register file's single write port among NUM_REQ writeback requesters (ALU, load unit, CSR unit).
//  - Round-robin arbitration with valid/ready handshake per requester.
//  - One registered writeback stage; drives the register file's rd write interface.
//  - Counts contention cycles for performance analysis.
// PARAMETERS
//  NUM_REQ    3   number of writeback requesters (2..8)
//  XLEN       32  data width
//  ADDR_W     5   register address width
//  CNT_W      16  contention counter width
// PORTS
//  clk              in   1               clock, all state on rising edge
//  rst              in   1               asynchronous, active-high reset
//  reqValid_In      in   NUM_REQ         requester i has a write pending
//  reqReady_Out     out  NUM_REQ         one-hot grant; transfer when valid&ready
//  reqAddr_In       in   NUM_REQ*ADDR_W  dest register, requester i at [i*ADDR_W +: ADDR_W]
//  reqData_In       in   NUM_REQ*XLEN    write data, requester i at [i*XLEN +: XLEN]
//  rdAddr_Out       out  ADDR_W          to register file write address
//  rd_Out           out  XLEN            to register file write data
//  rdEnable_Out     out  1               to register file write enable
//  rs1Addr_In       in   ADDR_W          read-port-1 address (bypass compare)
//  rs1Data_In       in   XLEN            register file read-port-1 data
//  rs1Fwd_Out       out  XLEN            read-port-1 data after bypass
//  rs2Addr_In       in   ADDR_W          read-port-2 address
//  rs2Data_In       in   XLEN            register file read-port-2 data
//  rs2Fwd_Out       out  XLEN            read-port-2 data after bypass
//  conflictCnt_Out  out  CNT_W           cycles with >1 requester valid, saturating
// BEHAVIOUR
//  - Reset (async, any time): rdEnable_Out=0, rdAddr_Out=0, rd_Out=0, rrPtr=0, conflictCnt_Out=0; reqReady_Out=0 while rst high.
//  - Grant (comb.): first i with reqValid_In[i], searching from rrPtr upward, wrapping at NUM_REQ; reqReady_Out one-hot or zero.
//  - Write port never stalls: exactly one request accepted every cycle any valid is high.
//  - reqReady_Out depends on reqValid_In and rrPtr only, never on other ready signals.
//  - Latency 1: request accepted in cycle N -> rdEnable_Out=1, rdAddr_Out/rd_Out = its addr/data in cycle N+1.
//  - No acceptance in cycle N -> rdEnable_Out=0 in N+1; rdAddr_Out/rd_Out hold their previous values.
//  - Write to x0: accepted (ready asserted, pointer advances), but rdEnable_Out=0 next cycle.
//  - rrPtr on acceptance of i: (i+1) mod NUM_REQ; explicit wrap, no power-of-2 assumption; unchanged if idle.
//  - Requester holding valid is granted within NUM_REQ cycles (starvation-free).
//  - conflictCnt_Out: +1 each cycle popcount(reqValid_In)>=2; holds at 2^CNT_W-1.
//  - Two requesters naming the same register in one cycle: only the granted one is written; the other waits.
// CONFIGURATION
//  - `WB_BYPASS_EN defined: rsXFwd_Out = rd_Out when rdEnable_Out && rdAddr_Out==rsXAddr_In && rsXAddr_In!=0.
//    Otherwise rsXFwd_Out = rsXData_In. Hides same-cycle write/read hazard.
//  - Undefined: rsXFwd_Out = rsXData_In always; ports remain, so the interface is identical.
// STRUCTURE
//  - regfile_pkg: XLEN, REG_ADDR_W, REG_ZERO (5'd0), WB_REQ_ALU/LSU/CSR index constants.
//  - Sub-module rr_picker: combinational NUM_REQ-wide round-robin first-one search (valid, ptr -> one-hot, index).
//  - Top: rr_picker, rrPtr register, writeback stage register, contention counter, bypass muxes.
// TESTING
//  - Single req: valid[1], addr 5, data 0xDEADBEEF -> ready[1] same cycle; next cycle rdEnable=1, rdAddr=5, rd=0xDEADBEEF.
//  - All 3 valid for 6 cycles after reset -> grants 0,1,2,0,1,2; conflictCnt=6.
//  - x0 write: req0 addr 0, data 0x1234 -> ready[0]=1, rdEnable=0 next cycle, rrPtr=1.
//  - Bypass (EN): write x7=0x55 then rs1Addr=7, rs1Data=0x11 -> rs1Fwd=0x55; undefined -> 0x11.
//  - Async rst mid-burst (no clock edge) -> rdEnable=0, conflictCnt=0 immediately; first grant after release goes to req0.
//  - CNT_W=4, continuous 2-way contention for 20 cycles -> conflictCnt saturates at 15.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Writeback requester slots
    localparam int unsigned WB_REQ_ALU = 0;
    localparam int unsigned WB_REQ_LSU = 1;
    localparam int unsigned WB_REQ_CSR = 2;

    // Width of an index into n requesters (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Combinational round-robin first-one search: starting at ptr, walk upward
// with an explicit wrap at NUM_REQ (no power-of-two assumption) and return
// the first valid slot as a one-hot grant plus its index.
module rr_picker
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    int unsigned idx;
    logic        found;

    // First valid requester at or after ptr, wrapping
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                index              = IDX_W'(idx);
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin shares the single rd write
// port among NUM_REQ requesters, registers one writeback stage, counts
// contention cycles and optionally bypasses the pending write onto the
// read ports. Define WB_BYPASS_EN to enable the read-port bypass.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = regfile_pkg::XLEN,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        reqValid_In,
    output logic [NUM_REQ-1:0]        reqReady_Out,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr_In,
    input  logic [NUM_REQ*XLEN-1:0]   reqData_In,
    output logic [ADDR_W-1:0]         rdAddr_Out,
    output logic [XLEN-1:0]           rd_Out,
    output logic                      rdEnable_Out,
    input  logic [ADDR_W-1:0]         rs1Addr_In,
    input  logic [XLEN-1:0]           rs1Data_In,
    output logic [XLEN-1:0]           rs1Fwd_Out,
    input  logic [ADDR_W-1:0]         rs2Addr_In,
    input  logic [XLEN-1:0]           rs2Data_In,
    output logic [XLEN-1:0]           rs2Fwd_Out,
    output logic [CNT_W-1:0]          conflictCnt_Out
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic               multi_valid;
    logic [ADDR_W-1:0]  sel_addr;
    logic [XLEN-1:0]    sel_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid (reqValid_In),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (grant_idx)
    );

    // Grant is suppressed while reset is asserted; otherwise any valid wins a slot
    assign reqReady_Out = rst ? '0 : grant;
    assign accept       = |grant;

    // Two or more valids: clearing the lowest set bit leaves something behind
    assign multi_valid  = |(reqValid_In & (reqValid_In - NUM_REQ'(1)));

    // Pointer moves to the slot after the winner, wrapping explicitly
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (accept) begin
            rr_ptr_nxt = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // AND-OR select of the granted requester's payload
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = reqAddr_In[i*ADDR_W +: ADDR_W];
                sel_data = reqData_In[i*XLEN +: XLEN];
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Writeback stage; x0 writes are consumed but never enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdEnable_Out <= 1'b0;
            rdAddr_Out   <= '0;
            rd_Out       <= '0;
        end else begin
            rdEnable_Out <= accept && (sel_addr != ADDR_W'(REG_ZERO));
            if (accept) begin
                rdAddr_Out <= sel_addr;
                rd_Out     <= sel_data;
            end
        end
    end

    // Saturating contention counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflictCnt_Out <= '0;
        end else if (multi_valid && (conflictCnt_Out != '1)) begin
            conflictCnt_Out <= conflictCnt_Out + CNT_W'(1);
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to a reader of the same non-zero register
    assign rs1Fwd_Out = (rdEnable_Out && (rdAddr_Out == rs1Addr_In) &&
                         (rs1Addr_In != ADDR_W'(REG_ZERO))) ? rd_Out : rs1Data_In;
    assign rs2Fwd_Out = (rdEnable_Out && (rdAddr_Out == rs2Addr_In) &&
                         (rs2Addr_In != ADDR_W'(REG_ZERO))) ? rd_Out : rs2Data_In;
`else
    // Pass-through read ports; addresses are kept for an identical interface
    logic unused_rs_addr;
    assign unused_rs_addr = ^{rs1Addr_In, rs2Addr_In};
    assign rs1Fwd_Out     = rs1Data_In;
    assign rs2Fwd_Out     = rs2Data_In;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic [ADDR_W-1:0]         rs1_addr, rs2_addr;
    logic [XLEN-1:0]           rs1_data, rs2_data;

    logic [NUM_REQ-1:0] ready_a, ready_b;
    logic [ADDR_W-1:0]  rd_addr_a, rd_addr_b;
    logic [XLEN-1:0]    rd_a, rd_b;
    logic               rd_en_a, rd_en_b;
    logic [XLEN-1:0]    fwd1_a, fwd2_a, fwd1_b, fwd2_b;
    logic [15:0]        cnt_a;
    logic [3:0]         cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .reqValid_In(req_valid), .reqReady_Out(ready_a),
        .reqAddr_In(req_addr), .reqData_In(req_data),
        .rdAddr_Out(rd_addr_a), .rd_Out(rd_a), .rdEnable_Out(rd_en_a),
        .rs1Addr_In(rs1_addr), .rs1Data_In(rs1_data), .rs1Fwd_Out(fwd1_a),
        .rs2Addr_In(rs2_addr), .rs2Data_In(rs2_data), .rs2Fwd_Out(fwd2_a),
        .conflictCnt_Out(cnt_a)
    );

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .reqValid_In(req_valid), .reqReady_Out(ready_b),
        .reqAddr_In(req_addr), .reqData_In(req_data),
        .rdAddr_Out(rd_addr_b), .rd_Out(rd_b), .rdEnable_Out(rd_en_b),
        .rs1Addr_In(rs1_addr), .rs1Data_In(rs1_data), .rs1Fwd_Out(fwd1_b),
        .rs2Addr_In(rs2_addr), .rs2Data_In(rs2_data), .rs2Fwd_Out(fwd2_b),
        .conflictCnt_Out(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*XLEN +: XLEN]     = d;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [XLEN-1:0] exp_fwd1, exp_fwd2;
        int g;

        rst       = 1'b1;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h200);
        set_req(2, 5'd3, 32'h300);

        // Held in reset with valids high
        tick();
        tick();
        check("rst_ready",   32'(ready_a),   32'h0);
        check("rst_rden",    32'(rd_en_a),   32'h0);
        check("rst_rdaddr",  32'(rd_addr_a), 32'h0);
        check("rst_rd",      rd_a,           32'h0);
        check("rst_cnt",     32'(cnt_a),     32'h0);

        do_reset();

        // Single request on slot 1
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        check("single_ready", 32'(ready_a), 32'h2);
        tick();
        check("single_rden",   32'(rd_en_a),   32'h1);
        check("single_rdaddr", 32'(rd_addr_a), 32'h5);
        check("single_rd",     rd_a,           32'hDEADBEEF);

        // Idle cycle holds address/data, drops enable
        req_valid = '0;
        tick();
        check("idle_rden",   32'(rd_en_a),   32'h0);
        check("idle_rdaddr", 32'(rd_addr_a), 32'h5);
        check("idle_rd",     rd_a,           32'hDEADBEEF);

        // Full contention for 6 cycles from a fresh pointer
        do_reset();
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h200);
        set_req(2, 5'd3, 32'h300);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g = k % 3;
            #1;
            check($sformatf("rr_ready_%0d", k), 32'(ready_a), 32'(1 << g));
            tick();
            check($sformatf("rr_rdaddr_%0d", k), 32'(rd_addr_a), 32'(g + 1));
            check($sformatf("rr_rd_%0d", k),     rd_a,           32'((g + 1) * 32'h100));
        end
        check("rr_cnt6", 32'(cnt_a), 32'd6);
        req_valid = '0;
        tick();
        check("rr_cnt_hold", 32'(cnt_a), 32'd6);

        // Write to x0 is accepted but not enabled, pointer still advances
        do_reset();
        set_req(0, 5'd0, 32'h1234);
        req_valid = 3'b001;
        #1;
        check("x0_ready", 32'(ready_a), 32'h1);
        tick();
        check("x0_rden", 32'(rd_en_a), 32'h0);

        // Same destination from two requesters: pointer at 1 picks slot 1 first
        set_req(0, 5'd9, 32'hAAAA);
        set_req(1, 5'd9, 32'hBBBB);
        req_valid = 3'b011;
        #1;
        check("same_ready_a", 32'(ready_a), 32'h2);
        tick();
        check("same_rd_a",   rd_a,           32'hBBBB);
        check("same_addr_a", 32'(rd_addr_a), 32'd9);
        #1;
        check("same_ready_b", 32'(ready_a), 32'h1);
        tick();
        check("same_rd_b",   rd_a,          32'hAAAA);
        check("same_rden_b", 32'(rd_en_a),  32'h1);

        // Bypass of the pending write onto the read ports
        set_req(2, 5'd7, 32'h55);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        rs1_addr  = 5'd7;
        rs1_data  = 32'h11;
        rs2_addr  = 5'd6;
        rs2_data  = 32'h22;
        #1;
`ifdef WB_BYPASS_EN
        exp_fwd1 = 32'h55;
`else
        exp_fwd1 = 32'h11;
`endif
        exp_fwd2 = 32'h22;
        check("byp_rs1", fwd1_a, exp_fwd1);
        check("byp_rs2_other", fwd2_a, exp_fwd2);
        tick();
        check("byp_rs1_after", fwd1_a, 32'h11);

        // Asynchronous reset in the middle of a burst
        do_reset();
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h200);
        set_req(2, 5'd3, 32'h300);
        req_valid = 3'b111;
        tick();
        tick();
        check("burst_cnt_pre", 32'(cnt_a), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rden",  32'(rd_en_a), 32'h0);
        check("async_cnt",   32'(cnt_a),   32'h0);
        check("async_ready", 32'(ready_a), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready_a), 32'h1);
        tick();
        check("post_rst_rdaddr", 32'(rd_addr_a), 32'd1);

        // Saturation of a narrow counter under two-way contention
        do_reset();
        req_valid = 3'b011;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check("sat_cnt4",  32'(cnt_b), 32'd15);
        check("sat_cnt16", 32'(cnt_a), 32'd20);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
